// File: rtl/serial_add_pkg.sv
// Shared types and constants for the serial adder controller.
// Holds the state encoding, default width and counter-width helper.
package serial_add_pkg;

  localparam int N_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_bit_counter.sv
// Bit counter for the serial adder: clear, enable, terminal count.
// o_tc is high while the count equals N-1.
module bit_counter
  import serial_add_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int W = cnt_width(N)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tc = (cnt_q == W'(N - 1));

endmodule

// File: rtl/serial_add_ctrl.sv
// Serial adder controller: load, N shift/add cycles, done pulse.
// SERIAL_ADD_CIN_EN adds i_cin, used as the carry loaded in LOAD.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_a_bit,
  input  logic i_b_bit,
`ifdef SERIAL_ADD_CIN_EN
  input  logic i_cin,
`endif
  output logic ld_A,
  output logic ld_B,
  output logic shift_A,
  output logic shift_B,
  output logic o_sum_bit,
  output logic o_carry,
  output logic o_busy,
  output logic o_done
);

  state_e state_q;
  state_e state_d;
  logic   carry_q;
  logic   carry_d;
  logic   ld;
  logic   shift;
  logic   sum;
  logic   busy;
  logic   done;
  logic   cnt_clr;
  logic   cnt_en;
  logic   cnt_tc;
  logic   cin_init;

`ifdef SERIAL_ADD_CIN_EN
  assign cin_init = i_cin;
`else
  assign cin_init = 1'b0;
`endif

  bit_counter #(
    .N (N)
  ) u_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (cnt_clr),
    .i_en  (cnt_en),
    .o_tc  (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    ld      = 1'b0;
    shift   = 1'b0;
    sum     = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) state_d = LOAD;
      end
      LOAD: begin
        ld      = 1'b1;
        busy    = 1'b1;
        cnt_clr = 1'b1;
        carry_d = cin_init;
        state_d = ADD;
      end
      ADD: begin
        shift   = 1'b1;
        busy    = 1'b1;
        cnt_en  = 1'b1;
        sum     = i_a_bit ^ i_b_bit ^ carry_q;
        carry_d = (i_a_bit & i_b_bit) |
                  (i_a_bit & carry_q) |
                  (i_b_bit & carry_q);
        if (cnt_tc) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
    end
  end

  assign ld_A      = ld;
  assign ld_B      = ld;
  assign shift_A   = shift;
  assign shift_B   = shift;
  assign o_sum_bit = sum;
  assign o_carry   = carry_q;
  assign o_busy    = busy;
  assign o_done    = done;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl with external operand registers.
// Expected sums come from plain N-bit arithmetic on the operands.
module tb_serial_add_ctrl;

  localparam int N = 8;
`ifdef SERIAL_ADD_CIN_EN
  localparam bit CIN_EN = 1'b1;
  logic cin = 1'b0;
`else
  localparam bit CIN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic ld_a, ld_b, sh_a, sh_b;
  logic sum_bit, carry, busy, done;
  logic [N-1:0] par_a = '0;
  logic [N-1:0] par_b = '0;
  logic [N-1:0] reg_a = '0;
  logic [N-1:0] reg_b = '0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Operand shift registers; the serial sum re-enters at the MSB of both.
  always @(posedge clk) begin
    if (ld_a) reg_a <= par_a;
    else if (sh_a) reg_a <= {sum_bit, reg_a[N-1:1]};
    if (ld_b) reg_b <= par_b;
    else if (sh_b) reg_b <= {sum_bit, reg_b[N-1:1]};
  end

  serial_add_ctrl #(.N(N)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_a_bit   (reg_a[0]),
    .i_b_bit   (reg_b[0]),
`ifdef SERIAL_ADD_CIN_EN
    .i_cin     (cin),
`endif
    .ld_A      (ld_a),
    .ld_B      (ld_b),
    .shift_A   (sh_a),
    .shift_B   (sh_b),
    .o_sum_bit (sum_bit),
    .o_carry   (carry),
    .o_busy    (busy),
    .o_done    (done)
  );

  function automatic logic [N:0] model(input logic [N-1:0] a,
                                       input logic [N-1:0] b,
                                       input logic c);
    return {1'b0, a} + {1'b0, b} + (N+1)'(c);
  endfunction

  // Start one operation at cycle 0 and observe cycles 1..14.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input int poke, input int rst_at,
                        output int done_cyc, output int ndone,
                        output logic [N-1:0] bits, output logic [7:0] snap,
                        output int viol);
    @(negedge clk);
    par_a = a;
    par_b = b;
    start = 1'b1;
    done_cyc = -1;
    ndone = 0;
    bits = '0;
    snap = '1;
    viol = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (cyc == rst_at + 1)
        snap = {ld_a, ld_b, sh_a, sh_b, sum_bit, busy, done, carry};
      if (sh_a) bits = {sum_bit, bits[N-1:1]};
      else if (sum_bit !== 1'b0) viol++;
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if ((ld_a | ld_b) && (sh_a | sh_b)) viol++;
      if (ld_a !== ld_b || sh_a !== sh_b) viol++;
      start = (cyc == poke);
      rst = (cyc == rst_at);
    end
    start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic check_op(input string tag, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic c);
    int dc, nd, vi;
    logic [N-1:0] bits;
    logic [7:0] snap;
    logic [N:0] exp;
    exp = model(a, b, c);
    run_op(a, b, -1, -1, dc, nd, bits, snap, vi);
    n_checks += 6;
    if (dc !== 10 || nd !== 1) begin
      n_fail++;
      $display("FAIL %s done: cycle %0d count %0d, expected cycle 10 count 1", tag, dc, nd);
    end
    if (reg_a !== exp[N-1:0]) begin
      n_fail++;
      $display("FAIL %s reg_a: got %h expected %h", tag, reg_a, exp[N-1:0]);
    end
    if (reg_b !== exp[N-1:0]) begin
      n_fail++;
      $display("FAIL %s reg_b: got %h expected %h", tag, reg_b, exp[N-1:0]);
    end
    if (carry !== exp[N]) begin
      n_fail++;
      $display("FAIL %s carry: got %b expected %b", tag, carry, exp[N]);
    end
    if (bits !== exp[N-1:0]) begin
      n_fail++;
      $display("FAIL %s sum_bits: got %h expected %h", tag, bits, exp[N-1:0]);
    end
    if (vi !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s strobes: violations %0d busy %b, expected 0 0", tag, vi, busy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ld_a, ld_b, sh_a, sh_b, sum_bit, busy, done, carry} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00000000",
               {ld_a, ld_b, sh_a, sh_b, sum_bit, busy, done, carry});
    end
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check_op("rst_ff01", 8'hFF, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (carry !== 1'b1) begin
      n_fail++;
      $display("FAIL carry_hold: got %b expected 1", carry);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (carry !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_carry: got %b expected 0", carry);
    end
  endtask

  task automatic test_vectors();
    logic [N-1:0] ta [4];
    logic [N-1:0] tb [4];
    ta = '{8'h35, 8'hFF, 8'h00, 8'h80};
    tb = '{8'h4A, 8'h01, 8'h00, 8'h80};
`ifdef SERIAL_ADD_CIN_EN
    cin = 1'b0;
`endif
    for (int i = 0; i < 4; i++)
      check_op($sformatf("vec%0d", i), ta[i], tb[i], 1'b0);
  endtask

  task automatic test_random();
    logic [N-1:0] a, b;
    logic c;
    for (int i = 0; i < 20; i++) begin
      a = N'($urandom);
      b = N'($urandom);
      c = CIN_EN ? 1'($urandom_range(0, 1)) : 1'b0;
`ifdef SERIAL_ADD_CIN_EN
      cin = c;
`endif
      check_op($sformatf("rand%0d", i), a, b, c);
    end
`ifdef SERIAL_ADD_CIN_EN
    cin = 1'b0;
`endif
  endtask

  task automatic test_start_ignored();
    int dc, nd, vi;
    logic [N-1:0] bits;
    logic [7:0] snap;
    run_op(8'h35, 8'h4A, 4, -1, dc, nd, bits, snap, vi);
    n_checks += 2;
    if (dc !== 10 || nd !== 1) begin
      n_fail++;
      $display("FAIL start_ignored done: cycle %0d count %0d, expected 10 1", dc, nd);
    end
    if (reg_a !== 8'h7F || carry !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ignored result: got %h/%b expected 7f/0", reg_a, carry);
    end
  endtask

  task automatic test_reset_abort();
    int dc, nd, vi;
    logic [N-1:0] bits;
    logic [7:0] snap;
    run_op(8'hFF, 8'h01, -1, 5, dc, nd, bits, snap, vi);
    n_checks += 2;
    if (snap !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_outputs: got %b expected 00000000", snap);
    end
    if (nd !== 0) begin
      n_fail++;
      $display("FAIL abort_done: got %0d pulses expected 0", nd);
    end
    check_op("after_abort", 8'h5A, 8'h3C, 1'b0);
  endtask

  task automatic test_back_to_back();
    int got[$];
    int exp[$];
    int t;
    t = 0;
    while (t < 30) begin
      exp.push_back(t + N + 2);
      t += N + 3;
    end
    @(negedge clk);
    par_a = 8'h12;
    par_b = 8'h34;
    start = 1'b1;
    for (int cyc = 1; cyc <= 36; cyc++) begin
      @(negedge clk);
      if (done) got.push_back(cyc);
      if (cyc == 30) start = 1'b0;
    end
    n_checks++;
    if (got.size() !== exp.size()) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d pulses expected %0d", got.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        n_checks++;
        if (got[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL b2b_done%0d: got cycle %0d expected %0d", i, got[i], exp[i]);
        end
      end
    end
  endtask

`ifdef SERIAL_ADD_CIN_EN
  task automatic test_cin();
    cin = 1'b1;
    check_op("cin_ff00", 8'hFF, 8'h00, 1'b1);
    cin = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_vectors();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_random();
`ifdef SERIAL_ADD_CIN_EN
    test_cin();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
